statled_multi: RTL

Multi-channel, parametrised status-LED blinker. It drives NUM_LED independent LEDs from per-channel status codes using a shared prescaler and a shared frame counter, so all channels blink in phase. Blink patterns are generated arithmetically from the status value (N pulses, then a gap), so there is no hard-coded code table. It sits at the top level beside the board LED pins and takes status from any internal block.

---
 rtl/statled_pkg.sv | 29 ++
 rtl/statled_chan.sv | 64 ++++++
 rtl/statled_multi.sv | 67 ++++++
 3 files changed

// File: rtl/statled_pkg.sv
// Shared helpers for the status-LED blinker: pattern generator and reset constants.
// Build option STATLED_STICKY_EN (used by statled_chan) latches short status events per frame.
package statled_pkg;

  localparam logic LED_RST = 1'b1;  // all LEDs lit during reset as a lamp test

  function automatic int unsigned max_code(input int unsigned frame_len);
    return (frame_len >> 1) - 1;
  endfunction

  function automatic int unsigned slot_rst(input int unsigned frame_len);
    return frame_len - 1;
  endfunction

  // s = 0: 50/50; 1..max_code: s pulses on even slots; above: solid on.
  function automatic logic statled_bit(input logic [7:0] s, input logic [31:0] k,
                                       input int unsigned frame_len);
    logic [31:0] sv;
    sv = 32'(s);
    if (sv == 32'd0) begin
      return k < (frame_len >> 1);
    end else if (sv <= max_code(frame_len)) begin
      return (k[0] == 1'b0) && (k < (sv << 1));
    end else begin
      return 1'b1;
    end
  endfunction

endpackage

// File: rtl/statled_chan.sv
// One LED channel: frame-aligned code register and registered LED bit.
// With STATLED_STICKY_EN, a hold register keeps the first nonzero status seen in a frame.
module statled_chan
  import statled_pkg::*;
#(
  parameter int unsigned STATUS_W  = 4,
  parameter int unsigned FRAME_LEN = 16,
  parameter int unsigned SLOT_W    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [STATUS_W-1:0] str,
  input  logic                tick,
  input  logic                boundary,
  input  logic [SLOT_W-1:0]   slot_nxt,
  output logic                led
);

  logic [STATUS_W-1:0] cur_q, cur_d;
  logic                led_d;

`ifdef STATLED_STICKY_EN
  logic [STATUS_W-1:0] hold_q, hold_d;

  // On the boundary a nonzero str reloads hold so an event on that edge isn't lost.
  always_comb begin
    cur_d  = cur_q;
    hold_d = hold_q;
    if (boundary) begin
      cur_d  = (hold_q != '0) ? hold_q : str;
      hold_d = str;
    end else if ((hold_q == '0) && (str != '0)) begin
      hold_d = str;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`else
  always_comb begin
    cur_d = boundary ? str : cur_q;
  end
`endif

  always_comb begin
    led_d = tick ? statled_bit(8'(cur_d), 32'(slot_nxt), FRAME_LEN) : led;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_q <= '0;
      led   <= LED_RST;
    end else begin
      cur_q <= cur_d;
      led   <= led_d;
    end
  end

endmodule

// File: rtl/statled_multi.sv
// Multi-channel status-LED blinker: shared prescaler and slot counter, one statled_chan per LED.
// Optional sticky capture of short status events is enabled by defining STATLED_STICKY_EN.
module statled_multi
  import statled_pkg::*;
#(
  parameter int unsigned NUM_LED      = 4,
  parameter int unsigned STATUS_W     = 4,
  parameter int unsigned FRAME_LEN    = 16,
  parameter int unsigned PULSE_CLKCNT = 25_000_000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_LED*STATUS_W-1:0]  status,
  output logic [NUM_LED-1:0]           led,
  output logic                         frame_start
);

  localparam int unsigned       SLOT_W    = $clog2(FRAME_LEN);
  localparam logic [31:0]       PRE_MAX   = 32'(PULSE_CLKCNT - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(slot_rst(FRAME_LEN));

  logic [31:0]                 pre_q, pre_d;
  logic [SLOT_W-1:0]           slot_q, slot_d;
  logic [NUM_LED*STATUS_W-1:0] str_q;
  logic                        tick, boundary;

  always_comb begin
    tick     = (pre_q == PRE_MAX);
    boundary = tick && (slot_q == SLOT_LAST);
    pre_d    = tick ? 32'd0 : pre_q + 32'd1;
    slot_d   = slot_q;
    if (tick) begin
      slot_d = boundary ? '0 : slot_q + SLOT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q       <= '0;
      slot_q      <= SLOT_LAST;
      str_q       <= '0;
      frame_start <= 1'b0;
    end else begin
      pre_q       <= pre_d;
      slot_q      <= slot_d;
      str_q       <= status;
      frame_start <= boundary;
    end
  end

  for (genvar i = 0; i < NUM_LED; i++) begin : g_chan
    statled_chan #(
      .STATUS_W (STATUS_W),
      .FRAME_LEN(FRAME_LEN),
      .SLOT_W   (SLOT_W)
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .str     (str_q[i*STATUS_W +: STATUS_W]),
      .tick    (tick),
      .boundary(boundary),
      .slot_nxt(slot_d),
      .led     (led[i])
    );
  end

endmodule
